icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache serving the Fetcher's request port. It takes `start_fetch`/`pc` from the Fetcher and returns a one-cycle `instr_ready` pulse with `instr`/`instr_addr`. Misses are refilled through a byte-wide read port on the memory arbiter, using four sequential byte reads assembled little-endian. A `rob_clear` aborts any lookup or refill in progress.

---
 rtl/icache_if.sv | 23 ++
 rtl/icache.sv | 159 +++++++++++++++
 tb/tb_icache.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch request/response and byte-wide arbiter read port of the instruction cache.
// Handshakes: start_fetch is held with pc until the one-cycle instr_ready pulse; a byte read is accepted in a cycle with mem_req && mem_gnt.
interface icache_if;
    logic        start_fetch;
    logic [31:0] pc;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_din;

    modport slave (
        input  start_fetch, pc, mem_gnt, mem_din,
        output instr_ready, instr, instr_addr, mem_req, mem_addr
    );

    modport master (
        output start_fetch, pc, mem_gnt, mem_din,
        input  instr_ready, instr, instr_addr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Misses are refilled by four byte reads assembled little-endian.
module icache #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       rob_clear,
    icache_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               req_cnt_q, req_cnt_d;
    logic [1:0]               recv_cnt_q, recv_cnt_d;
    logic                     pending_q, pending_d;
    logic [29:0]              line_addr_q, line_addr_d;
    logic [23:0]              fill_q, fill_d;
    logic                     instr_ready_q, instr_ready_d;
    logic [31:0]              instr_q, instr_d;
    logic [31:0]              instr_addr_q, instr_addr_d;
    logic [LINES-1:0]         valid_q, valid_d;
    logic [TAG_W-1:0]         tag_q [LINES];
    logic [31:0]              data_q [LINES];

    logic                     wr_en;
    logic [INDEX_WIDTH-1:0]   wr_idx;
    logic [TAG_W-1:0]         wr_tag;
    logic [INDEX_WIDTH-1:0]   pc_idx;
    logic [TAG_W-1:0]         pc_tag;
    logic [31:0]              pc_word;
    logic                     hit;
    logic [31:0]              fill_word;

    assign pc_word   = bus.pc & ~32'd3;
    assign pc_idx    = pc_word[INDEX_WIDTH+1:2];
    assign pc_tag    = pc_word[31:INDEX_WIDTH+2];
    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill_word = {bus.mem_din, fill_q};
    assign wr_idx    = line_addr_q[INDEX_WIDTH-1:0];
    assign wr_tag    = line_addr_q[29:INDEX_WIDTH];

    // Request lines depend only on registered state, never on inputs.
    assign bus.mem_req     = (state_q == MISS) && !req_cnt_q[2];
    assign bus.mem_addr    = bus.mem_req ? {line_addr_q, req_cnt_q[1:0]} : 32'd0;
    assign bus.instr_ready = instr_ready_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign dbg_state       = state_q;

    always_comb begin
        state_d       = state_q;
        req_cnt_d     = req_cnt_q;
        recv_cnt_d    = recv_cnt_q;
        pending_d     = pending_q;
        line_addr_d   = line_addr_q;
        fill_d        = fill_q;
        instr_ready_d = instr_ready_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        wr_en         = 1'b0;
        if (rdy) begin
            instr_ready_d = 1'b0;
            if (rob_clear) begin
                // Abort drops any partial fill and any byte still in flight.
                state_d   = IDLE;
                pending_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_fetch) begin
                            if (hit) begin
                                instr_d       = data_q[pc_idx];
                                instr_addr_d  = pc_word;
                                instr_ready_d = 1'b1;
                                state_d       = RESP;
                            end else begin
                                line_addr_d = pc_word[31:2];
                                req_cnt_d   = 3'd0;
                                recv_cnt_d  = 2'd0;
                                pending_d   = 1'b0;
                                state_d     = MISS;
                            end
                        end
                    end
                    MISS: begin
                        pending_d = bus.mem_req && bus.mem_gnt;
                        if (bus.mem_req && bus.mem_gnt) begin
                            req_cnt_d = req_cnt_q + 3'd1;
                        end
                        if (pending_q) begin
                            recv_cnt_d = recv_cnt_q + 2'd1;
                            case (recv_cnt_q)
                                2'd0: fill_d[7:0]   = bus.mem_din;
                                2'd1: fill_d[15:8]  = bus.mem_din;
                                2'd2: fill_d[23:16] = bus.mem_din;
                                default: begin
                                    wr_en         = 1'b1;
                                    instr_d       = fill_word;
                                    instr_addr_d  = {line_addr_q, 2'b00};
                                    instr_ready_d = 1'b1;
                                    state_d       = RESP;
                                end
                            endcase
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_cnt_q     <= 3'd0;
            recv_cnt_q    <= 2'd0;
            pending_q     <= 1'b0;
            line_addr_q   <= 30'd0;
            fill_q        <= 24'd0;
            instr_ready_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_addr_q  <= 32'd0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_cnt_q     <= req_cnt_d;
            recv_cnt_q    <= recv_cnt_d;
            pending_q     <= pending_d;
            line_addr_q   <= line_addr_d;
            fill_q        <= fill_d;
            instr_ready_q <= instr_ready_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            valid_q       <= valid_d;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= fill_word;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed timing scenarios plus random fetches against a line-address model.
// A negedge environment plays the arbiter and rdy; a monitor pops expected responses.
module tb_icache;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b1;
    logic       rob_clear = 1'b0;
    logic [1:0] dbg_state;

    icache_if bus();

    icache #(.INDEX_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .rob_clear (rob_clear),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ready = 0;
    int          last_issue = 0;

    // Memory contents: fixed bytes for the cold-miss word, arithmetic pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            default: return 8'(a[9:2] * 8'd29 + {6'd0, a[1:0]} * 8'd71 + a[17:10] + 8'h3c);
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_byte(b + 3), mem_byte(b + 2), mem_byte(b + 1), mem_byte(b)};
    endfunction

    // Reference: which word-address each of the 16 lines holds.
    logic        m_valid [16];
    logic [29:0] m_line  [16];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[5:2]);
        return m_valid[idx] && (m_line[idx] == a[31:2]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        m_valid[int'(a[5:2])] = 1'b1;
        m_line[int'(a[5:2])]  = a[31:2];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Arbiter and rdy environment.
    int          rdy_hold = 0;
    int          gnt_mode = 1;
    logic        gnt_pat[$];
    logic        gnt_seen = 1'b0;
    logic [31:0] gnt_addr = 32'd0;
    int          n_grants = 0;
    int          g_cyc[$];
    logic [31:0] g_addr[$];

    always @(negedge clk) begin
        if (gnt_seen) bus.mem_din = mem_byte(gnt_addr);
        if (rdy_hold > 0) begin
            rdy = 1'b0;
            rdy_hold--;
        end else begin
            rdy = 1'b1;
        end
        if (bus.mem_req && gnt_pat.size() > 0) bus.mem_gnt = gnt_pat.pop_front();
        else if (gnt_mode == 1) bus.mem_gnt = 1'b1;
        else bus.mem_gnt = 1'($urandom_range(0, 1));
        gnt_seen = rdy && bus.mem_req && bus.mem_gnt && rst_n;
        if (gnt_seen) begin
            gnt_addr = bus.mem_addr;
            n_grants++;
            g_cyc.push_back(cyc);
            g_addr.push_back(bus.mem_addr);
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.instr_ready) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got response addr 0x%0h, expected none", bus.instr_addr);
            end else begin
                e = exp_q.pop_front();
                check("instr", bus.instr, e.word);
                check("instr_addr", bus.instr_addr, e.addr);
                if (e.lat >= 0) check("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    // lat: explicit expected latency, -1 unchecked, -2 derive from the model (hit = 1).
    task automatic do_fetch(input logic [31:0] pc, input int lat);
        exp_t e;
        int   g0;
        int   t;
        bit   was_hit;
        @(negedge clk);
        was_hit = model_hit(pc);
        e.addr  = {pc[31:2], 2'b00};
        e.word  = mem_word(pc);
        e.issue = cyc;
        e.lat   = (lat == -2) ? (was_hit ? 1 : -1) : lat;
        exp_q.push_back(e);
        model_fill(pc);
        last_issue = cyc;
        g0 = n_grants;
        bus.start_fetch = 1'b1;
        bus.pc = pc;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.instr_ready && t < 300);
        bus.start_fetch = 1'b0;
        if (t >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no instr_ready for pc 0x%0h, expected within 300 cycles", pc);
            exp_q.delete();
        end
        check("grant_count", 32'(n_grants - g0), was_hit ? 32'd0 : 32'd4);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_instr_ready"}, 32'(bus.instr_ready), 32'd0);
        check({tag, "_instr"}, bus.instr, 32'd0);
        check({tag, "_instr_addr"}, bus.instr_addr, 32'd0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int n0;
        bit stall;
        logic [31:0] rpc;
        bus.start_fetch = 1'b0;
        bus.pc = 32'd0;
        bus.mem_din = 8'd0;
        bus.mem_gnt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Cold miss, then back-to-back hits.
        g_cyc.delete();
        g_addr.delete();
        do_fetch(32'h100, 6);
        check("cold_grants", 32'(g_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_cyc.size(); i++) begin
            check("cold_req_cycle", 32'(g_cyc[i] - last_issue), 32'(i + 1));
            check("cold_req_addr", g_addr[i], 32'h100 + 32'(i));
        end
        do_fetch(32'h100, 1);
        do_fetch(32'h102, 1);

        // Conflict on index 0.
        do_fetch(32'h140, 6);
        do_fetch(32'h100, 6);

        // Arbiter stalls.
        g_cyc.delete();
        g_addr.delete();
        gnt_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_fetch(32'h180, 9);
        check("stall_grants", 32'(g_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_cyc.size(); i++)
            check("stall_grant_cycle", 32'(g_cyc[i] - last_issue), 32'(2 * i + 1));

        // Flush in cycle 3 of a miss.
        @(negedge clk);
        n0 = n_ready;
        bus.start_fetch = 1'b1;
        bus.pc = 32'h200;
        repeat (3) @(negedge clk);
        rob_clear = 1'b1;
        bus.start_fetch = 1'b0;
        @(negedge clk);
        rob_clear = 1'b0;
        check("flush_mem_req", 32'(bus.mem_req), 32'd0);
        repeat (10) @(negedge clk);
        check("flush_no_ready", 32'(n_ready - n0), 32'd0);
        check("flush_state", 32'(dbg_state), 32'd0);
        do_fetch(32'h200, 6);
        do_fetch(32'h200, 1);

        // Asynchronous reset in cycle 2 of a miss.
        @(negedge clk);
        bus.start_fetch = 1'b1;
        bus.pc = 32'h240;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.start_fetch = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h240, 6);
        do_fetch(32'h100, 6);

        // rdy low for 3 cycles during a miss.
        fork
            do_fetch(32'h2c0, 9);
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                rdy_hold = 3;
            end
        join

        // Random fetches with a random arbiter and occasional rdy stalls.
        gnt_mode = 0;
        for (int i = 0; i < 60; i++) begin
            rpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            stall = ($urandom_range(0, 4) == 0);
            if (stall) begin
                @(posedge clk);
                rdy_hold = $urandom_range(1, 3);
            end
            do_fetch(rpc, stall ? -1 : -2);
        end

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
